// File: rtl/mem_access_unit.sv
// Data-memory access unit: formats stores onto a word bus, formats loads back, and stalls the pipe for the handshake.
// Optional feature DMEM_TIMEOUT_EN: abandon an access after 255 unacknowledged WAIT cycles and flag BusErrM.
`timescale 1ns/1ps
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = 4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic              we_q, we_d;
  logic [BEW-1:0]    be_q, be_d;

  logic              is_word, is_half, aligned, access, misalign_c;
  logic [BEW-1:0]    be_fmt;
  logic [XLEN-1:0]   wdata_fmt, rd_sh, load_fmt;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNTW = 8;
  localparam logic [CNTW-1:0]  TIMEOUT_LAST = CNTW'(254);
  localparam logic [XLEN-1:0]  BUS_ERR_DATA = 32'hDEAD_BEEF;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              buserr_q, buserr_d;
`endif

  // Request decode and store-lane formatting from the live instruction
  always_comb begin
    is_word    = MemSizeM[1];
    is_half    = (MemSizeM == 2'b01);
    aligned    = is_word ? (ALUOutM[1:0] == 2'b00) : (is_half ? ~ALUOutM[0] : 1'b1);
    access     = (MemReadM | MemWriteM) & aligned;
    misalign_c = (MemReadM | MemWriteM) & ~aligned;
    if (is_word) begin
      be_fmt    = 4'b1111;
      wdata_fmt = WriteDataM;
    end else if (is_half) begin
      be_fmt    = ALUOutM[1] ? 4'b1100 : 4'b0011;
      wdata_fmt = {2{WriteDataM[15:0]}};
    end else begin
      be_fmt    = BEW'(4'b0001 << ALUOutM[1:0]);
      wdata_fmt = {4{WriteDataM[7:0]}};
    end
  end

  // Load formatting from the latched lane, size and sign
  always_comb begin
    rd_sh = dmem_rdata >> {addr_q[1:0], 3'b000};
    if (size_q[1]) begin
      load_fmt = dmem_rdata;
    end else if (size_q[0]) begin
      load_fmt = {{16{sign_q & rd_sh[15]}}, rd_sh[15:0]};
    end else begin
      load_fmt = {{24{sign_q & rd_sh[7]}}, rd_sh[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      sign_q   <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= '0;
      buserr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      we_q     <= we_d;
      be_q     <= be_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
      buserr_q <= buserr_d;
`endif
    end
  end

  // Next state and latched-register updates
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    sign_d   = sign_q;
    we_d     = we_q;
    be_d     = be_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d    = cnt_q;
    buserr_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (access) begin
          state_d = S_WAIT;
          addr_d  = ALUOutM;
          wdata_d = wdata_fmt;
          size_d  = MemSizeM;
          sign_d  = MemSignedM;
          we_d    = MemWriteM;
          be_d    = be_fmt;
`ifdef DMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = load_fmt;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d  = S_DONE;
          rdata_d  = BUS_ERR_DATA;
          buserr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; the handshake and stall are forced low while reset is asserted
  always_comb begin
    StallM     = rst & (((state_q == S_IDLE) & access) | (state_q == S_WAIT));
    MisalignM  = rst & (state_q == S_IDLE) & misalign_c;
    dmem_req   = rst & (state_q == S_WAIT);
    dmem_we    = rst & we_q;
    dmem_be    = rst ? be_q : '0;
    dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
    dmem_wdata = wdata_q;
    ReadDataM  = rdata_q;
`ifdef DMEM_TIMEOUT_EN
    BusErrM    = buserr_q;
`else
    BusErrM    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit, checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        MemReadM, MemWriteM, MemSignedM;
  logic [1:0]  MemSizeM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM), .MemSignedM(MemSignedM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state and the expected outputs for the current cycle
  logic        chk_en = 1'b0;
  logic [31:0] m_rd;
  logic        exp_stall, exp_mis, exp_req, exp_berr, exp_bus, exp_rstchk;
  logic        exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] d, input logic [31:0] a,
                                         input logic [1:0] sz, input logic sg);
    int unsigned bits, v;
    if (sz[1]) return d;
    bits = (sz == 2'b01) ? 16 : 8;
    v = (d >> (8 * a[1:0])) & ((32'd1 << bits) - 1);
    if (sg && v >= (32'd1 << (bits - 1))) v = v | ~((32'd1 << bits) - 1);
    return v;
  endfunction

  function automatic logic [31:0] m_st_data(input logic [31:0] wd, input logic [1:0] sz);
    if (sz[1]) return wd;
    if (sz == 2'b01) return (wd & 32'h0000FFFF) * 32'h00010001;
    return (wd & 32'h000000FF) * 32'h01010101;
  endfunction

  function automatic logic [3:0] m_st_be(input logic [31:0] a, input logic [1:0] sz);
    if (sz[1]) return 4'b1111;
    if (sz == 2'b01) return 4'(4'b0011 << (a[1] ? 2 : 0));
    return 4'(4'b0001 << a[1:0]);
  endfunction

  task automatic set_exp(input logic st, input logic mis, input logic req);
    exp_stall  = st;
    exp_mis    = mis;
    exp_req    = req;
    exp_bus    = req;
    exp_rstchk = 1'b0;
    exp_berr   = 1'b0;
  endtask

  // Per-cycle comparison against the model's expectations
  always @(negedge clk) begin
    if (chk_en) begin
      check("StallM",    32'(StallM),    32'(exp_stall));
      check("MisalignM", 32'(MisalignM), 32'(exp_mis));
      check("dmem_req",  32'(dmem_req),  32'(exp_req));
      check("ReadDataM", ReadDataM,      m_rd);
      check("BusErrM",   32'(BusErrM),   32'(exp_berr));
      if (exp_bus) begin
        check("dmem_we",    32'(dmem_we), 32'(exp_we));
        check("dmem_addr",  dmem_addr,    exp_addr);
        check("dmem_wdata", dmem_wdata,   exp_wdata);
        check("dmem_be",    32'(dmem_be), 32'(exp_be));
      end
      if (exp_rstchk) begin
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_be", 32'(dmem_be), 32'd0);
      end
    end
  end

  // One instruction through the unit; ack_dly = WAIT cycles before the acking one
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_dly,
                        input logic [31:0] rdat);
    logic al, acc, tmo;
    int   n_wait;
    al  = sz[1] ? (a[1:0] == 2'b00) : ((sz == 2'b01) ? !a[0] : 1'b1);
    acc = (rd | wr) && al;
    MemReadM = rd; MemWriteM = wr; MemSizeM = sz; MemSignedM = sg;
    ALUOutM = a; WriteDataM = wd;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    set_exp(acc, (rd | wr) && !al, 1'b0);
    @(posedge clk); #1;
    if (!acc) return;
`ifdef DMEM_TIMEOUT_EN
    tmo = (ack_dly > 254);
`else
    tmo = 1'b0;
`endif
    n_wait    = tmo ? 255 : ack_dly + 1;
    exp_we    = wr;
    exp_addr  = a & 32'hFFFFFFFC;
    exp_wdata = m_st_data(wd, sz);
    exp_be    = m_st_be(a, sz);
    for (int k = 0; k < n_wait; k++) begin
      dmem_ack   = !tmo && (k == ack_dly);
      dmem_rdata = dmem_ack ? rdat : $urandom;
      set_exp(1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    set_exp(1'b0, 1'b0, 1'b0);
    if (tmo) begin
      m_rd     = 32'hDEADBEEF;
      exp_berr = 1'b1;
    end else if (!wr) begin
      m_rd = m_load(rdat, a, sz, sg);
    end
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    MemReadM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10; MemSignedM = 1'b0;
    ALUOutM = 32'h0000_0101; WriteDataM = '0; dmem_ack = 1'b1; dmem_rdata = $urandom;
    m_rd = '0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    set_exp(1'b0, 1'b0, 1'b0);
    exp_rstchk = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MemReadM = 1'($urandom_range(0, 1)); MemWriteM = 1'($urandom_range(0, 1));
      MemSizeM = 2'($urandom_range(0, 3)); ALUOutM = $urandom; dmem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst = 1'b1;

    // Pin the model with hand-computed values
    check("pin_ld_sbyte", m_load(32'h80112233, 32'h103, 2'b00, 1'b1), 32'hFFFFFF80);
    check("pin_ld_ubyte", m_load(32'h80112233, 32'h103, 2'b00, 1'b0), 32'h00000080);
    check("pin_st_wdata", m_st_data(32'h0000BEEF, 2'b01), 32'hBEEFBEEF);
    check("pin_st_be",    32'(m_st_be(32'h202, 2'b01)), 32'h0000000C);

    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'h89ABCDEF);
    check("word_load_0x100", ReadDataM, 32'h89ABCDEF);
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h80112233);
    check("sbyte_load_0x103", ReadDataM, 32'hFFFFFF80);
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80112233);
    check("ubyte_load_0x103", ReadDataM, 32'h00000080);
    run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 2, 32'h12345678);
    check("half_store_keeps_rd", ReadDataM, 32'h00000080);
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h11111111);
    check("misalign_keeps_rd", ReadDataM, 32'h00000080);
    run_op(1'b1, 1'b1, 2'b11, 1'b0, 32'h204, 32'hCAFEF00D, 1, 32'h22222222);
    check("rd_wr_is_store", ReadDataM, 32'h00000080);

    for (int i = 0; i < 150; i++) begin
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 4)), $urandom);
    end

    // Reset in the second WAIT cycle, then a late ack
    MemReadM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10; MemSignedM = 1'b0;
    ALUOutM = 32'h300; dmem_ack = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    exp_we = 1'b0; exp_addr = 32'h300; exp_wdata = WriteDataM; exp_be = 4'hF;
    set_exp(1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    exp_rstchk = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; m_rd = '0; MemReadM = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    set_exp(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    check("rd_after_reset", ReadDataM, 32'h0);

    // Long wait: timeout when enabled, otherwise the access just waits for the ack
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 300, 32'h0BADF00D);
`ifdef DMEM_TIMEOUT_EN
    check("timeout_rd", ReadDataM, 32'hDEADBEEF);
`else
    check("long_wait_rd", ReadDataM, 32'h0BADF00D);
`endif
    run_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 0, 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous reset, active-low (clears state when sampled 0 at posedge clk).
REQ-002 SHALL have ports: MemReadM  in  1  load; MemWriteM  in  1  store; MemSizeM  in  2  00 byte, 01 half, 10 word, 11 treated as word; MemSignedM  in  1  sign-extend load.
REQ-003 SHALL have ports: ALUOutM  in  32  byte address; WriteDataM  in  32  store data.
REQ-004 SHALL have ports: ReadDataM  out  32  formatted load data to MEM/WB; StallM  out  1  freeze IF..EX/MEM; MisalignM  out  1  misaligned access flag; BusErrM  out  1  bus timeout flag.
REQ-005 SHALL have bus ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32  word-aligned; dmem_wdata  out  32; dmem_be  out  4; dmem_ack  in  1; dmem_rdata  in  32.

Function
REQ-006 SHALL implement FSM IDLE, WAIT, DONE; reset state IDLE.
REQ-007 IDLE: access = (MemReadM|MemWriteM) & aligned; access -> WAIT, latching address, size, sign, we, byte enables and store data; else stay IDLE.
REQ-008 StallM SHALL be 1 combinationally in IDLE with access, and in every WAIT cycle; 0 in DONE and otherwise.
REQ-009 dmem_req SHALL be 1 only in WAIT; dmem_we/addr/wdata/be SHALL be driven from latched registers and stay stable while dmem_req=1.
REQ-010 WAIT: dmem_ack=1 -> DONE (ack allowed in the first WAIT cycle); load data SHALL be formatted and registered into ReadDataM on that edge.
REQ-011 DONE SHALL last exactly one cycle then return to IDLE without re-issuing the still-present instruction; minimum access latency 3 cycles (IDLE, WAIT, DONE).
REQ-012 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-013 MemWriteM and MemReadM both 1 SHALL be a store only; ReadDataM unchanged.
REQ-014 dmem_addr SHALL equal {ALUOutM[31:2],2'b00}.
REQ-015 Store: byte -> wdata = byte replicated x4, be = 4'b0001<<addr[1:0]; half -> half replicated x2, be = 4'b0011<<(2*addr[1]); word -> be 4'b1111.
REQ-016 Load: byte lane addr[1:0], half lane addr[1]; zero-extend, or sign-extend when MemSignedM=1; word passes unchanged.
REQ-017 ReadDataM SHALL hold its value until the next load completes; stores SHALL NOT modify it.
REQ-018 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus cycle, no stall, MisalignM=1 combinationally that cycle, ReadDataM unchanged.

Reset
REQ-019 rst=0 SHALL set state IDLE, ReadDataM=0, BusErrM=0, latched registers 0; StallM, MisalignM, dmem_req, dmem_we and dmem_be SHALL read 0 while rst=0.
REQ-020 Reset during WAIT SHALL drop dmem_req the cycle after; a late ack SHALL be ignored.

Configuration
REQ-021 With DMEM_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack; after 255 consecutive WAIT cycles without ack the FSM SHALL go to DONE, setting ReadDataM=32'hDEADBEEF and BusErrM=1 for the DONE cycle only.
REQ-022 Without DMEM_TIMEOUT_EN: no counter; WAIT holds indefinitely; BusErrM tied 0.

Verification
REQ-023 Word load addr 0x100, ack on first WAIT cycle, rdata 0x89ABCDEF -> StallM 1 for 2 cycles, ReadDataM=0x89ABCDEF in DONE.
REQ-024 Signed byte load addr 0x103, rdata 0x80112233 -> ReadDataM=0xFFFFFF80; unsigned -> 0x00000080.
REQ-025 Half store addr 0x202, WriteDataM 0x0000BEEF, ack after 3 WAIT cycles -> dmem_be=1100, dmem_wdata=0xBEEFBEEF stable 3 cycles, dmem_addr=0x200.
REQ-026 Word load addr 0x101 -> MisalignM=1, dmem_req never 1, StallM=0.
REQ-027 rst=0 in second WAIT cycle, ack one cycle later -> state IDLE, dmem_req 0, ReadDataM=0; with DMEM_TIMEOUT_EN and ack never asserted -> BusErrM=1 and ReadDataM=0xDEADBEEF in the cycle after the 255th WAIT cycle.
